// File: rtl/peri_reg_init.sv
// peri_reg_init: bridges single Wishbone classic accesses onto the peripheral
// register bus. A no-ack timeout turns a dead or unmapped address into an
// error response, so the bus never stalls.
module peri_reg_init #(
  parameter int          AW          = 11,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic          mclk,
  input  logic          s_reset_n,
  input  logic          wbd_cyc_i,
  input  logic          wbd_stb_i,
  input  logic          wbd_we_i,
  input  logic [AW-1:0] wbd_adr_i,
  input  logic [31:0]   wbd_dat_i,
  input  logic [3:0]    wbd_sel_i,
  output logic [31:0]   wbd_dat_o,
  output logic          wbd_ack_o,
  output logic          wbd_err_o,
  output logic          reg_cs,
  output logic          reg_wr,
  output logic [AW-1:0] reg_addr,
  output logic [31:0]   reg_wdata,
  output logic [3:0]    reg_be,
  input  logic [31:0]   reg_rdata,
  input  logic          reg_ack,
  output logic          busy
);

  // The counter only has to reach TIMEOUT_CYC-1, so clog2 of the limit is enough.
  localparam int            CW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit            TIMEOUT_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          cyc_lost, cyc_lost_d;
  logic          lost_now;

  logic          reg_cs_d;
  logic          reg_wr_d;
  logic [AW-1:0] reg_addr_d;
  logic [31:0]   reg_wdata_d;
  logic [3:0]    reg_be_d;
  logic [31:0]   dat_d;
  logic          ack_d;
  logic          err_d;
  logic          busy_d;

  // Next-state and next-output logic; every output is computed here and then registered.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    cyc_lost_d  = cyc_lost;
    reg_cs_d    = reg_cs;
    reg_wr_d    = reg_wr;
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    reg_be_d    = reg_be;
    dat_d       = wbd_dat_o;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    // Once the master drops cyc during a request its response is suppressed,
    // but the register-bus transfer still runs to completion.
    lost_now    = cyc_lost | ~wbd_cyc_i;

    case (state)
      IDLE: begin
        dat_d = '0;
        if (wbd_cyc_i && wbd_stb_i) begin
          reg_cs_d    = 1'b1;
          reg_wr_d    = wbd_we_i;
          reg_addr_d  = wbd_adr_i;
          reg_wdata_d = wbd_dat_i;
          reg_be_d    = wbd_sel_i;
          cnt_d       = '0;
          cyc_lost_d  = 1'b0;
          state_d     = REQ;
        end
      end

      REQ: begin
        cyc_lost_d = lost_now;
        if (reg_ack) begin
          reg_cs_d = 1'b0;
          dat_d    = reg_wr ? 32'h0 : reg_rdata;
          ack_d    = ~lost_now;
          state_d  = DONE;
        end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
          reg_cs_d = 1'b0;
          dat_d    = ERR_RDATA;
          err_d    = ~lost_now;
          state_d  = DONE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end

      DONE: begin
        dat_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge mclk) begin
    if (!s_reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cyc_lost  <= 1'b0;
      reg_cs    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_be    <= '0;
      wbd_dat_o <= '0;
      wbd_ack_o <= 1'b0;
      wbd_err_o <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cyc_lost  <= cyc_lost_d;
      reg_cs    <= reg_cs_d;
      reg_wr    <= reg_wr_d;
      reg_addr  <= reg_addr_d;
      reg_wdata <= reg_wdata_d;
      reg_be    <= reg_be_d;
      wbd_dat_o <= dat_d;
      wbd_ack_o <= ack_d;
      wbd_err_o <= err_d;
      busy      <= busy_d;
    end
  end

endmodule
